gpr_file_scoreboard: RTL and testbench
======================================

// Module: gpr_file_scoreboard
// PURPOSE
//  MIPS general-purpose register file with a pending-write scoreboard. Consumes the
//  register numbers r1/r2 from the read selector in ID, and the write number rw and
//  write data reg_din from the write and writeback-data selectors in WB. Provides
//  bypassed read data plus per-operand busy flags, which hazard control uses to stall ID.
// PARAMETERS
//  DATA_W   32  register width
//  CNT_W    2   width of each per-register in-flight write counter (max 2**CNT_W-1 in flight)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  resetn       in   1       asynchronous active-low reset
//  r1           in   5       read address port 1 (ID)
//  r2           in   5       read address port 2 (ID)
//  r1_dout      out  DATA_W  read data port 1
//  r2_dout      out  DATA_W  read data port 2
//  r1_busy      out  1       r1 has an uncommitted older write in flight
//  r2_busy      out  1       r2 has an uncommitted older write in flight
//  issue_valid  in   1       ID instruction leaves ID this cycle and will write issue_rw
//  issue_rw     in   5       destination register of issuing instruction
//  issue_ready  out  1       low = counter of issue_rw saturated; ID must hold
//  flush        in   1       squash all instructions younger than WB
//  wb_valid     in   1       WB instruction commits this cycle and was scoreboarded
//  wb_we        in   1       WB instruction actually writes (0 = e.g. cancelled movz/exception)
//  rw           in   5       WB destination register
//  reg_din      in   DATA_W  WB write data
// BEHAVIOUR
//  - Reset (resetn=0, async): all 31 registers and all counters -> 0; outputs then
//    r1_dout=r2_dout=0, r1_busy=r2_busy=0, issue_ready=1.
//  - Register 0: reads always 0; writes to 0 dropped; issue/wb with rw=0 never touch counters.
//  - Write: on posedge when wb_valid & wb_we & rw!=0, reg[rw] <= reg_din.
//  - Read: combinational, zero latency. Same-cycle bypass: if wb_valid & wb_we & rw==rX
//    & rX!=0 then rX_dout = reg_din, else reg[rX].
//  - Counter cnt[n] (CNT_W bits): inc = issue_valid & issue_ready & issue_rw==n;
//    dec = wb_valid & rw==n (regardless of wb_we). inc&dec same cycle -> unchanged.
//    dec with cnt==0 is a protocol error: counter holds at 0 (no wrap); sim assertion fires.
//  - issue_ready = (issue_rw==0) | (cnt[issue_rw] != 2**CNT_W-1). issue_valid while
//    issue_ready=0 is ignored (no increment).
//  - Busy: rX_busy = (rX!=0) & (cnt[rX] - (wb_valid & rw==rX) != 0), i.e. a write
//    committing this cycle clears busy combinationally (value is bypassed).
//  - flush: on posedge all counters -> 0; the same-cycle WB write still commits
//    (WB is older than flushed stages); same-cycle issue is discarded.
//  - Simultaneous flush and resetn low: reset dominates.
//  - No other state; no FSM beyond counters. Reads during reset return 0.
// TESTING
//  1 reset: drop resetn mid-run after writing reg5=0x1234 -> r1=5 reads 0, busy 0, immediately (async).
//  2 write/read: wb_valid=wb_we=1, rw=8, reg_din=0xDEADBEEF -> same cycle r1=8 dout=0xDEADBEEF
//    (bypass); next cycle still 0xDEADBEEF from array; rw=0 write -> r2=0 reads 0.
//  3 scoreboard: issue rw=3 -> next cycle r1=3 busy=1; issue rw=3 twice more -> cnt=3,
//    issue_ready=0, 4th issue ignored; three wb commits of rw=3 -> busy clears in cycle of 3rd wb.
//  4 simultaneous inc/dec: cnt[7]=1, same cycle issue rw=7 and wb rw=7 -> cnt stays 1, busy=1
//    next cycle; wb with wb_we=0 still decrements and leaves data unchanged.
//  5 flush: cnt[9]=2, cnt[10]=1, flush with wb rw=9 data 0x55 & issue rw=11 -> all busy 0
//    next cycle, reg9=0x55, cnt[11]=0.
//  6 underflow: wb_valid rw=4 with cnt[4]=0 -> cnt stays 0, assertion reported, data written.

Source files
------------

// File: rtl/gpr_file_scoreboard_if.sv
// Register-file bus: ID read ports, issue handshake, and WB commit port.
interface gpr_file_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        r1;
  logic [4:0]        r2;
  logic [DATA_W-1:0] r1_dout;
  logic [DATA_W-1:0] r2_dout;
  logic              r1_busy;
  logic              r2_busy;
  logic              issue_valid;
  logic [4:0]        issue_rw;
  logic              issue_ready;
  logic              flush;
  logic              wb_valid;
  logic              wb_we;
  logic [4:0]        rw;
  logic [DATA_W-1:0] reg_din;

  // Pipeline side: drives addresses, issue and commit, consumes read data.
  modport master (
    output r1, r2, issue_valid, issue_rw, flush, wb_valid, wb_we, rw, reg_din,
    input  r1_dout, r2_dout, r1_busy, r2_busy, issue_ready
  );

  // Register file side.
  modport slave (
    input  r1, r2, issue_valid, issue_rw, flush, wb_valid, wb_we, rw, reg_din,
    output r1_dout, r2_dout, r1_busy, r2_busy, issue_ready
  );
endinterface

// File: rtl/gpr_file_scoreboard.sv
// MIPS GPR file (31 writable registers, r0 hardwired to zero) with a
// per-register count of in-flight writes. Reads are combinational with a
// same-cycle bypass from the WB port; busy flags let ID stall on RAW hazards.
module gpr_file_scoreboard #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input logic                  clk,
  input logic                  resetn,
  gpr_file_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [32];
  logic [CNT_W-1:0]  cnt_q  [32];
  logic [CNT_W-1:0]  cnt_d  [32];

  logic wb_fire;
  logic issue_fire;

  // Bypass is gated by resetn so reads during reset return zero.
  assign wb_fire    = resetn & bus.wb_valid & bus.wb_we & (bus.rw != 5'd0);
  assign issue_fire = bus.issue_valid & bus.issue_ready;

  assign bus.issue_ready = (bus.issue_rw == 5'd0) || (cnt_q[bus.issue_rw] != CNT_MAX);

  // Combinational read ports with WB bypass and busy derivation.
  always_comb begin
    bus.r1_dout = '0;
    bus.r2_dout = '0;
    bus.r1_busy = 1'b0;
    bus.r2_busy = 1'b0;
    if (resetn && bus.r1 != 5'd0) begin
      bus.r1_dout = (wb_fire && bus.rw == bus.r1) ? bus.reg_din : regs_q[bus.r1];
      // A commit this cycle retires one pending write; busy only if more remain.
      bus.r1_busy = (cnt_q[bus.r1] != '0) &&
                    !(bus.wb_valid && bus.rw == bus.r1 && cnt_q[bus.r1] == CNT_ONE);
    end
    if (resetn && bus.r2 != 5'd0) begin
      bus.r2_dout = (wb_fire && bus.rw == bus.r2) ? bus.reg_din : regs_q[bus.r2];
      bus.r2_busy = (cnt_q[bus.r2] != '0) &&
                    !(bus.wb_valid && bus.rw == bus.r2 && cnt_q[bus.r2] == CNT_ONE);
    end
  end

  // Next-state of the in-flight counters; flush wins over issue/commit,
  // decrement at zero holds instead of wrapping.
  always_comb begin
    for (int n = 0; n < 32; n++) begin
      logic inc;
      logic dec;
      inc      = issue_fire && (bus.issue_rw == 5'(n)) && (n != 0);
      dec      = bus.wb_valid && (bus.rw == 5'(n)) && (n != 0);
      cnt_d[n] = cnt_q[n];
      if (bus.flush) begin
        cnt_d[n] = '0;
      end else if (inc && !dec) begin
        cnt_d[n] = cnt_q[n] + CNT_ONE;
      end else if (dec && !inc && cnt_q[n] != '0) begin
        cnt_d[n] = cnt_q[n] - CNT_ONE;
      end
    end
  end

  // Register array write; WB commits even in a flush cycle since it is older.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 32; n++) regs_q[n] <= '0;
    end else if (wb_fire) begin
      regs_q[bus.rw] <= bus.reg_din;
    end
  end

  // Counter state update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 32; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < 32; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  // Commit without a matching issue is a pipeline protocol error.
  always @(posedge clk) begin
    if (resetn && bus.wb_valid && bus.rw != 5'd0) begin
      underflow_chk: assert (cnt_q[bus.rw] != '0)
        else $warning("gpr_file_scoreboard: commit to r%0d with no write in flight", bus.rw);
    end
  end

endmodule

// File: tb/tb_gpr_file_scoreboard.sv
// Bench for gpr_file_scoreboard: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array/integer model.
module tb_gpr_file_scoreboard;

  localparam int DATA_W = 32;
  localparam int MAXCNT = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  gpr_file_scoreboard_if #(.DATA_W(DATA_W)) bus ();

  gpr_file_scoreboard #(.DATA_W(DATA_W), .CNT_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: register values and pending-write counts as plain ints.
  logic [31:0] m_reg [32];
  int          m_cnt [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return (bus.issue_rw == 5'd0) || (m_cnt[bus.issue_rw] < MAXCNT);
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] a);
    if (!resetn || a == 5'd0) return 32'h0;
    if (bus.wb_valid && bus.wb_we && bus.rw == a) return bus.reg_din;
    return m_reg[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    int pending;
    if (!resetn || a == 5'd0) return 1'b0;
    pending = m_cnt[a] - ((bus.wb_valid && bus.rw == a) ? 1 : 0);
    return pending > 0;
  endfunction

  // Model state update at each clock edge, async reset.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 32; n++) begin
        m_reg[n] = 32'h0;
        m_cnt[n] = 0;
      end
    end else begin
      logic rdy;
      rdy = m_ready();
      if (bus.wb_valid && bus.wb_we && bus.rw != 5'd0) m_reg[bus.rw] = bus.reg_din;
      if (bus.flush) begin
        for (int n = 0; n < 32; n++) m_cnt[n] = 0;
      end else begin
        if (bus.issue_valid && rdy && bus.issue_rw != 5'd0) m_cnt[bus.issue_rw]++;
        if (bus.wb_valid && bus.rw != 5'd0 && m_cnt[bus.rw] > 0) m_cnt[bus.rw]--;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("r1_dout", bus.r1_dout, m_dout(bus.r1));
      chk("r2_dout", bus.r2_dout, m_dout(bus.r2));
      chk("r1_busy", 32'(bus.r1_busy), 32'(m_busy(bus.r1)));
      chk("r2_busy", 32'(bus.r2_busy), 32'(m_busy(bus.r2)));
      chk("issue_ready", 32'(bus.issue_ready), 32'(m_ready()));
    end
  end

  // Drive one cycle of inputs just after the rising edge; returns 1ns later.
  task automatic cyc(input logic iv, input logic [4:0] irw, input logic fl,
                     input logic wv, input logic we, input logic [4:0] wrw,
                     input logic [31:0] din, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    bus.issue_valid = iv;
    bus.issue_rw    = irw;
    bus.flush       = fl;
    bus.wb_valid    = wv;
    bus.wb_we       = we;
    bus.rw          = wrw;
    bus.reg_din     = din;
    bus.r1          = a1;
    bus.r2          = a2;
    #1;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, a1, a2);
  endtask

  initial begin
    bus.issue_valid = 0; bus.issue_rw = 0; bus.flush = 0;
    bus.wb_valid = 0; bus.wb_we = 0; bus.rw = 0; bus.reg_din = 0;
    bus.r1 = 0; bus.r2 = 0;
    #1;
    chk("rst_r1_dout", bus.r1_dout, 32'h0);
    chk("rst_ready", 32'(bus.issue_ready), 32'h1);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    cmp_en = 1'b1;

    // write / read with bypass; r0 write dropped
    cyc(1, 8, 0, 0, 0, 0, 32'h0, 8, 0);
    cyc(0, 0, 0, 1, 1, 8, 32'hDEADBEEF, 8, 0);
    chk("wr_bypass", bus.r1_dout, 32'hDEADBEEF);
    chk("wr_bypass_busy", 32'(bus.r1_busy), 32'h0);
    cyc(0, 0, 0, 1, 1, 0, 32'h777, 8, 0);
    chk("wr_array", bus.r1_dout, 32'hDEADBEEF);
    chk("r0_zero", bus.r2_dout, 32'h0);

    // scoreboard saturation and drain
    cyc(1, 3, 0, 0, 0, 0, 32'h0, 3, 0);
    chk("sb_busy0", 32'(bus.r1_busy), 32'h0);
    cyc(1, 3, 0, 0, 0, 0, 32'h0, 3, 0);
    chk("sb_busy1", 32'(bus.r1_busy), 32'h1);
    cyc(1, 3, 0, 0, 0, 0, 32'h0, 3, 0);
    chk("sb_ready_cnt2", 32'(bus.issue_ready), 32'h1);
    cyc(1, 3, 0, 0, 0, 0, 32'h0, 3, 0);
    chk("sb_ready_sat", 32'(bus.issue_ready), 32'h0);
    cyc(0, 0, 0, 1, 1, 3, 32'h31, 3, 0);
    chk("sb_wb1_busy", 32'(bus.r1_busy), 32'h1);
    cyc(0, 0, 0, 1, 1, 3, 32'h32, 3, 0);
    chk("sb_wb2_busy", 32'(bus.r1_busy), 32'h1);
    cyc(0, 0, 0, 1, 1, 3, 32'h33, 3, 0);
    chk("sb_wb3_busy", 32'(bus.r1_busy), 32'h0);
    chk("sb_wb3_dout", bus.r1_dout, 32'h33);
    idle(3, 0);
    chk("sb_drained", 32'(bus.r1_busy), 32'h0);

    // simultaneous inc/dec; wb_we=0 decrements without writing
    cyc(1, 7, 0, 0, 0, 0, 32'h0, 7, 0);
    cyc(1, 7, 0, 1, 1, 7, 32'hA, 7, 0);
    idle(7, 0);
    chk("incdec_busy", 32'(bus.r1_busy), 32'h1);
    chk("incdec_dout", bus.r1_dout, 32'hA);
    cyc(0, 0, 0, 1, 0, 7, 32'hBAD, 7, 0);
    chk("nowe_dout", bus.r1_dout, 32'hA);
    idle(7, 0);
    chk("nowe_busy", 32'(bus.r1_busy), 32'h0);

    // flush: counters clear, WB commits, issue discarded
    cyc(1, 9, 0, 0, 0, 0, 32'h0, 9, 10);
    cyc(1, 9, 0, 0, 0, 0, 32'h0, 9, 10);
    cyc(1, 10, 0, 0, 0, 0, 32'h0, 9, 10);
    cyc(1, 11, 1, 1, 1, 9, 32'h55, 9, 10);
    idle(9, 10);
    chk("fl_busy9", 32'(bus.r1_busy), 32'h0);
    chk("fl_busy10", 32'(bus.r2_busy), 32'h0);
    chk("fl_reg9", bus.r1_dout, 32'h55);
    idle(11, 0);
    chk("fl_busy11", 32'(bus.r1_busy), 32'h0);

    // underflow: counter holds, data written
    cyc(0, 0, 0, 1, 1, 4, 32'h44, 4, 0);
    idle(4, 0);
    chk("uf_dout", bus.r1_dout, 32'h44);
    chk("uf_busy", 32'(bus.r1_busy), 32'h0);
    cyc(1, 4, 0, 0, 0, 0, 32'h0, 4, 0);
    idle(4, 0);
    chk("uf_cnt_one", 32'(bus.r1_busy), 32'h1);
    cyc(0, 0, 0, 1, 1, 4, 32'h45, 4, 0);

    // async reset mid-run
    cyc(1, 5, 0, 0, 0, 0, 32'h0, 5, 0);
    cyc(0, 0, 0, 1, 1, 5, 32'h1234, 5, 0);
    cyc(1, 5, 0, 0, 0, 0, 32'h0, 5, 0);
    idle(5, 0);
    chk("pre_rst_dout", bus.r1_dout, 32'h1234);
    chk("pre_rst_busy", 32'(bus.r1_busy), 32'h1);
    resetn = 1'b0;
    #1;
    chk("rst_async_dout", bus.r1_dout, 32'h0);
    chk("rst_async_busy", 32'(bus.r1_busy), 32'h0);
    #4 resetn = 1'b1;
    idle(5, 0);
    chk("post_rst_dout", bus.r1_dout, 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] wrw;
      logic       wv;
      wrw = 5'($urandom_range(0, 31));
      wv  = (m_cnt[wrw] > 0) || (wrw == 5'd0 && $urandom_range(0, 1) == 1);
      cyc(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
          ($urandom_range(0, 40) == 0), wv, ($urandom_range(0, 4) != 0), wrw,
          $urandom(),
          ($urandom_range(0, 3) == 0) ? wrw : 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)));
    end

    idle(0, 0);
    @(posedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
